gpio_cmd_loader: RTL
====================

# gpio_cmd_loader

- Parametrised GPIO command front-end for the 2D convolution datapath.
- Decodes toggle-handshaked 32-bit words from the soft processor's output GPIO.
- Loads the M_LEN×M_LEN kernel registers and writes image bytes into one of N_CH channel RAMs.
- Launches and tracks a convolution run, and returns status plus the latched result on the input GPIO.
- Sits between the processor GPIO pair and the memory/convolution core, replacing direct GPIO-to-RAM wiring.

## Interface
Parameters:
- BIT_LEN, 8, pixel/coefficient width
- CONV_LEN, 20, convolution result width (must be ≤ GPIO_D-8)
- M_LEN, 3, kernel side length
- NB_ADDRESS, 10, RAM address width
- RAM_DEPTH, 1024, words per channel RAM (≤ 2^NB_ADDRESS)
- N_CH, 3, number of channel RAMs (≤ 16)
- GPIO_D, 32, GPIO word width

Ports (one clock; reset is synchronous, active-high):
- CLK100MHZ  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_gpio_data  in  GPIO_D  command word from processor: [3:0] opcode, [4] toggle, [GPIO_D-1:8] payload
- o_gpio_data  out  GPIO_D  status:
  - [0] ack toggle
  - [1] busy
  - [2] err (sticky)
  - [3] frame_done (sticky)
  - [7:4] current channel
  - [GPIO_D-1:8] read data
- o_ram_we  out  N_CH  one-hot write enable, one-cycle pulse
- o_ram_addr  out  NB_ADDRESS  write address
- o_ram_data  out  BIT_LEN  write data
- o_kernel  out  M_LEN*M_LEN*BIT_LEN  kernel coefficients, index 0 in LSBs
- o_start  out  1  one-cycle convolution launch pulse
- i_conv_done  in  1  one-cycle completion pulse from the core
- i_result  in  CONV_LEN  convolution result
- o_led  out  1  mirrors kernel_ready

## Operation
- Input stage: i_gpio_data is registered into gpio_q.
- A command is accepted when gpio_q[4] != last_tog.
- In the accept cycle, last_tog and ack (o_gpio_data[0]) both take gpio_q[4]. Every accepted command toggles ack, including rejected ones.
- FSM states:
  - IDLE → RUN on an accepted START when kernel_ready=1.
  - RUN → IDLE on i_conv_done or CLEAR.
  - busy = (state == RUN).
- Opcodes:
  - 0 NOP: no action.
  - 1 LOAD_KERNEL: writes payload[BIT_LEN-1:0] to kernel[kidx], then kidx++.
    - When kidx reaches M_LEN², kidx wraps to 0 and kernel_ready is set.
    - Further loads overwrite from index 0; kernel_ready stays set.
  - 2 SET_CHANNEL: if payload < N_CH, chan takes the payload and addr is cleared to 0; otherwise err is set and chan is unchanged.
  - 3 WRITE_DATA: pulses o_ram_we[chan] with o_ram_addr=addr and o_ram_data=payload[BIT_LEN-1:0], then addr++.
    - At addr = RAM_DEPTH-1: addr wraps to 0 and frame_done is set.
  - 4 START: if kernel_ready, pulses o_start and enters RUN; otherwise sets err and stays in IDLE.
  - 5 READ: latches i_result, zero-extended, into o_gpio_data[GPIO_D-1:8].
  - 6 CLEAR:
    - Zeroes addr, kidx, kernel_ready, err, frame_done and chan.
    - Forces IDLE.
    - Kernel registers keep their contents.
  - 7–15: reserved; set err.
- While busy, LOAD_KERNEL, WRITE_DATA, SET_CHANNEL and START are rejected (err set, no side effect). READ, NOP and CLEAR execute normally.
- If i_conv_done and an accepted command fall in the same cycle, the command is judged against busy as it was before that edge. The FSM still returns to IDLE at that edge.
- i_conv_done in IDLE is ignored.

## Timing
- Reset values: every output is 0, the kernel registers are 0, state=IDLE, last_tog=0.
- Latency: a word applied before edge E1 is captured at E1. Its effects (o_ram_we, o_start, ack toggle, status, read data) are registered at E2 and visible after E2.
- o_ram_we and o_start are high for exactly one cycle per accepted command.
- o_ram_addr and o_ram_data hold their last values between writes.
- Throughput: one command per toggle. A new toggle may be presented as soon as ack matches it.
- Reset asserted mid-RUN returns the block to IDLE at the next edge with no o_start and no write.

## Configuration
- GPIO_SYNC_EN:
  - Defined: a two-flop synchronizer is inserted ahead of gpio_q. Latency becomes 3 cycles (effects after E3). Used when the GPIO sits in an asynchronous clock domain.
  - Undefined: a single register stage with the 2-cycle latency above.
  - Functional behaviour is otherwise identical.

## Test plan
- Reset, then 9 LOAD_KERNEL commands with payloads 1..9, toggling bit 4 on each → o_kernel = 0x090807060504030201, o_led=1, ack flips 9 times, err=0.
- SET_CHANNEL 1, then WRITE_DATA payloads 0x00..0x23 → o_ram_we=3'b010 for 36 single-cycle pulses, addresses 0..35, with o_ram_data equal to the payload each time.
- RAM_DEPTH=4, channel 0, 5 writes → addresses 0,1,2,3,0; frame_done=1 after the 4th write.
- START with kernel_ready=0 → err=1, no o_start. Then load the kernel and START → a single o_start pulse and busy=1. WRITE_DATA while busy → err, no o_ram_we. i_conv_done → busy=0.
- i_result=20'hABCDE, then READ → o_gpio_data[31:8]=24'h0ABCDE. SET_CHANNEL 5 with N_CH=3 → err=1, chan unchanged. CLEAR → err=0, o_led=0, kernel registers unchanged.
- Same-cycle i_conv_done and WRITE_DATA acceptance → write rejected, err=1, state IDLE. Repeat with GPIO_SYNC_EN defined and check effects appear one cycle later.

Source files
------------

// File: rtl/gpio_cmd_loader_if.sv
// Bundle of the processor GPIO pair and the memory/convolution core signals.
// The slave modport is the command loader; master is the processor/core side.
interface gpio_cmd_loader_if #(
   parameter int unsigned BIT_LEN    = 8,
   parameter int unsigned CONV_LEN   = 20,
   parameter int unsigned M_LEN      = 3,
   parameter int unsigned NB_ADDRESS = 10,
   parameter int unsigned N_CH       = 3,
   parameter int unsigned GPIO_D     = 32
) ();
   logic [GPIO_D-1:0]             i_gpio_data;
   logic [GPIO_D-1:0]             o_gpio_data;
   logic [N_CH-1:0]               o_ram_we;
   logic [NB_ADDRESS-1:0]         o_ram_addr;
   logic [BIT_LEN-1:0]            o_ram_data;
   logic [M_LEN*M_LEN*BIT_LEN-1:0] o_kernel;
   logic                          o_start;
   logic                          i_conv_done;
   logic [CONV_LEN-1:0]           i_result;
   logic                          o_led;

   modport slave (
      input  i_gpio_data, i_conv_done, i_result,
      output o_gpio_data, o_ram_we, o_ram_addr, o_ram_data, o_kernel, o_start, o_led
   );

   modport master (
      output i_gpio_data, i_conv_done, i_result,
      input  o_gpio_data, o_ram_we, o_ram_addr, o_ram_data, o_kernel, o_start, o_led
   );
endinterface

// File: rtl/gpio_cmd_loader.sv
// GPIO command front-end: kernel loads, channel RAM writes, convolution launch and status.
// Define GPIO_SYNC_EN to put a synchronizer flop ahead of gpio_q (gpio_q is the second stage).
module gpio_cmd_loader #(
   parameter int unsigned BIT_LEN    = 8,
   parameter int unsigned CONV_LEN   = 20,
   parameter int unsigned M_LEN      = 3,
   parameter int unsigned NB_ADDRESS = 10,
   parameter int unsigned RAM_DEPTH  = 1024,
   parameter int unsigned N_CH       = 3,
   parameter int unsigned GPIO_D     = 32
) (
   input logic              CLK100MHZ,
   input logic              i_rst,
   gpio_cmd_loader_if.slave bus
);
   localparam int unsigned KN = M_LEN * M_LEN;
   localparam int unsigned KW = (KN > 1) ? $clog2(KN) : 1;
   localparam int unsigned PW = GPIO_D - 8;

   localparam logic [3:0] OpNop        = 4'd0;
   localparam logic [3:0] OpLoadKernel = 4'd1;
   localparam logic [3:0] OpSetChannel = 4'd2;
   localparam logic [3:0] OpWriteData  = 4'd3;
   localparam logic [3:0] OpStart      = 4'd4;
   localparam logic [3:0] OpRead       = 4'd5;
   localparam logic [3:0] OpClear      = 4'd6;

   typedef enum logic {StIdle, StRun} state_e;

   state_e                        state_q;
   logic [GPIO_D-1:0]             gpio_in;
   logic [GPIO_D-1:0]             gpio_q;
   logic                          last_tog_q;
   logic                          ack_q;
   logic                          err_q;
   logic                          frame_done_q;
   logic                          kernel_ready_q;
   logic [3:0]                    chan_q;
   logic [NB_ADDRESS-1:0]         addr_q;
   logic [KW-1:0]                 kidx_q;
   logic [KN-1:0][BIT_LEN-1:0]    kernel_q;
   logic [PW-1:0]                 rd_data_q;
   logic [N_CH-1:0]               ram_we_q;
   logic [NB_ADDRESS-1:0]         ram_addr_q;
   logic [BIT_LEN-1:0]            ram_data_q;
   logic                          start_q;

   logic                          accept;
   logic                          busy;
   logic [3:0]                    opcode;
   logic [PW-1:0]                 payload;
   logic                          unused_bits;

`ifdef GPIO_SYNC_EN
   logic [GPIO_D-1:0] sync_q;

   always_ff @(posedge CLK100MHZ) begin
      if (i_rst) sync_q <= '0;
      else       sync_q <= bus.i_gpio_data;
   end

   assign gpio_in = sync_q;
`else
   assign gpio_in = bus.i_gpio_data;
`endif

   assign opcode      = gpio_q[3:0];
   assign payload     = gpio_q[GPIO_D-1:8];
   assign accept      = gpio_q[4] != last_tog_q;
   assign busy        = state_q == StRun;
   assign unused_bits = ^gpio_q[7:5];

   always_ff @(posedge CLK100MHZ) begin
      if (i_rst) begin
         state_q        <= StIdle;
         gpio_q         <= '0;
         last_tog_q     <= 1'b0;
         ack_q          <= 1'b0;
         err_q          <= 1'b0;
         frame_done_q   <= 1'b0;
         kernel_ready_q <= 1'b0;
         chan_q         <= '0;
         addr_q         <= '0;
         kidx_q         <= '0;
         kernel_q       <= '0;
         rd_data_q      <= '0;
         ram_we_q       <= '0;
         ram_addr_q     <= '0;
         ram_data_q     <= '0;
         start_q        <= 1'b0;
      end else begin
         gpio_q   <= gpio_in;
         ram_we_q <= '0;
         start_q  <= 1'b0;
         // Completion returns to idle; commands in this cycle still see the old busy.
         if (busy && bus.i_conv_done) state_q <= StIdle;
         if (accept) begin
            last_tog_q <= gpio_q[4];
            ack_q      <= gpio_q[4];
            case (opcode)
               OpNop: ;
               OpLoadKernel: begin
                  if (busy) begin
                     err_q <= 1'b1;
                  end else begin
                     kernel_q[kidx_q] <= payload[BIT_LEN-1:0];
                     if (kidx_q == KW'(KN - 1)) begin
                        kidx_q         <= '0;
                        kernel_ready_q <= 1'b1;
                     end else begin
                        kidx_q <= kidx_q + 1'b1;
                     end
                  end
               end
               OpSetChannel: begin
                  if (busy || payload >= PW'(N_CH)) begin
                     err_q <= 1'b1;
                  end else begin
                     chan_q <= payload[3:0];
                     addr_q <= '0;
                  end
               end
               OpWriteData: begin
                  if (busy) begin
                     err_q <= 1'b1;
                  end else begin
                     ram_we_q   <= N_CH'(1) << chan_q;
                     ram_addr_q <= addr_q;
                     ram_data_q <= payload[BIT_LEN-1:0];
                     if (addr_q == NB_ADDRESS'(RAM_DEPTH - 1)) begin
                        addr_q       <= '0;
                        frame_done_q <= 1'b1;
                     end else begin
                        addr_q <= addr_q + 1'b1;
                     end
                  end
               end
               OpStart: begin
                  if (busy || !kernel_ready_q) begin
                     err_q <= 1'b1;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= StRun;
                  end
               end
               OpRead: rd_data_q <= PW'(bus.i_result);
               OpClear: begin
                  addr_q         <= '0;
                  kidx_q         <= '0;
                  kernel_ready_q <= 1'b0;
                  err_q          <= 1'b0;
                  frame_done_q   <= 1'b0;
                  chan_q         <= '0;
                  state_q        <= StIdle;
               end
               default: err_q <= 1'b1;
            endcase
         end
      end
   end

   assign bus.o_gpio_data = {rd_data_q, chan_q, frame_done_q, err_q, busy, ack_q};
   assign bus.o_ram_we    = ram_we_q;
   assign bus.o_ram_addr  = ram_addr_q;
   assign bus.o_ram_data  = ram_data_q;
   assign bus.o_kernel    = kernel_q;
   assign bus.o_start     = start_q;
   assign bus.o_led       = kernel_ready_q;
endmodule
